// File: rtl/mode_select_ctrl_if.sv
// Pin-side signals of the mode selector: raw buttons/switch in, mode code out.
interface mode_select_ctrl_if;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [2:0] state;
    logic       state_changed;

    modport master (
        output btn_next, btn_prev, auto_en,
        input  state, state_changed
    );

    modport slave (
        input  btn_next, btn_prev, auto_en,
        output state, state_changed
    );
endinterface

// File: rtl/mode_select_ctrl.sv
// Display-mode selector: synchronises and debounces next/prev buttons,
// steps a wrap-around mode code and optionally auto-advances on a timer.

// One button channel: two-flop synchroniser followed by a level debouncer.
module msc_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic raw,
    output logic db
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from db for the full window;
    // any bounce back to db restarts the count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (s2 == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module mode_select_ctrl #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_CYCLES     = 50000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    mode_select_ctrl_if.slave bus
);
    localparam int            AW        = $clog2(AUTO_CYCLES);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);
    localparam logic [2:0]    LAST_MODE = 3'(NUM_MODES - 1);

    // Bit 0 is the next button, bit 1 the prev button.
    logic [1:0]    btn_raw, btn_db, btn_db_q, press;
    logic          any_press;
    logic          a_s1, a_s2;
    logic [AW-1:0] auto_cnt;
    logic          auto_tick;
    logic [2:0]    state_q, state_nxt;
    logic          chg_q;

    assign btn_raw = {bus.btn_prev, bus.btn_next};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        msc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .raw     (btn_raw[i]),
            .db      (btn_db[i])
        );
    end

    // Delay debounced levels one cycle so a press is a single-cycle rising-edge pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) btn_db_q <= '0;
        else         btn_db_q <= btn_db;
    end

    assign press     = btn_db & ~btn_db_q;
    assign any_press = |press;

    // The slide switch only needs synchronising; it is a slow level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
        end else begin
            a_s1 <= bus.auto_en;
            a_s2 <= a_s1;
        end
    end

    assign auto_tick = a_s2 && (auto_cnt == AUTO_LAST);

    // Auto-advance timer; a press (even a cancelled pair) restarts the period.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || any_press || !a_s2 || auto_tick) auto_cnt <= '0;
        else                                            auto_cnt <= auto_cnt + 1'b1;
    end

    // Next mode: presses beat the timer, and opposite presses cancel out.
    always_comb begin
        state_nxt = state_q;
        if (press == 2'b01 || (press == 2'b00 && auto_tick))
            state_nxt = (state_q == LAST_MODE) ? 3'd0 : state_q + 3'd1;
        else if (press == 2'b10)
            state_nxt = (state_q == 3'd0) ? LAST_MODE : state_q - 3'd1;
    end

    // Mode register with a change flag registered alongside it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= 3'd0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            chg_q   <= (state_nxt != state_q);
        end
    end

    assign bus.state         = state_q;
    assign bus.state_changed = chg_q;
endmodule

// File: tb/tb_mode_select_ctrl.sv
// Bench for mode_select_ctrl: a cycle model derived from the behavioural rules
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_mode_select_ctrl;
    localparam int NM = 4;
    localparam int DB = 8;
    localparam int AC = 32;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    mode_select_ctrl_if bus();

    mode_select_ctrl #(
        .NUM_MODES       (NM),
        .DEBOUNCE_CYCLES (DB),
        .AUTO_CYCLES     (AC)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int cyc      = 0;
    bit armed    = 0;

    // Model state: raw samples from one and two edges ago, debounced level,
    // run length of disagreement, pending press, auto period progress, mode.
    bit raw_h1 [2];
    bit raw_h2 [2];
    bit m_db   [2];
    int streak [2];
    bit pend   [2];
    bit au_h1, au_h2;
    int since;
    int m_state;
    bit m_chg;
    bit pn, pp, tick;
    int nst;

    // Reference model, advanced once per clock edge.
    always @(posedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            for (int b = 0; b < 2; b++) begin
                raw_h1[b] = 0; raw_h2[b] = 0; m_db[b] = 0; streak[b] = 0; pend[b] = 0;
            end
            au_h1 = 0; au_h2 = 0; since = 0; m_state = 0; m_chg = 0;
        end else begin
            pn = pend[0];
            pp = pend[1];
            tick = 0;
            if (pn || pp || !au_h2) since = 0;
            else begin
                since++;
                if (since == AC) begin tick = 1; since = 0; end
            end
            nst = m_state;
            if ((pn && !pp) || (!pn && !pp && tick)) nst = (m_state + 1) % NM;
            else if (pp && !pn)                      nst = (m_state + NM - 1) % NM;
            m_chg   = (nst != m_state);
            m_state = nst;
            for (int b = 0; b < 2; b++) begin
                pend[b] = 0;
                if (raw_h2[b] != m_db[b]) begin
                    streak[b]++;
                    if (streak[b] == DB) begin
                        m_db[b]   = raw_h2[b];
                        streak[b] = 0;
                        pend[b]   = m_db[b];
                    end
                end else begin
                    streak[b] = 0;
                end
            end
            raw_h2 = raw_h1;
            raw_h1[0] = bus.btn_next;
            raw_h1[1] = bus.btn_prev;
            au_h2 = au_h1;
            au_h1 = bus.auto_en;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge sys_clk) begin
        if (armed) begin
            checks++;
            if (bus.state !== 3'(m_state) || bus.state_changed !== m_chg) begin
                failures++;
                $display("FAIL model_cmp cyc=%0d state got=%0d want=%0d chg got=%0b want=%0b",
                         cyc, bus.state, m_state, bus.state_changed, m_chg);
            end
            if (bus.state_changed === 1'b1) pulses++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic press(input int b);
        if (b == 0) bus.btn_next = 1'b1; else bus.btn_prev = 1'b1;
        step(12);
        if (b == 0) bus.btn_next = 1'b0; else bus.btn_prev = 1'b0;
        step(12);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
    endtask

    task automatic wait_change(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (bus.state_changed === 1'b1) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            failures++;
            $display("FAIL wait_change got=timeout want=pulse within 200 cycles");
        end
    endtask

    int p0, t1, t2, t3, t4, t5, t6;

    initial begin
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        bus.auto_en  = 1'b0;
        step(2);
        armed   = 1;
        sys_rst = 1'b0;

        // Idle after reset.
        p0 = pulses;
        chk("reset_state", int'(bus.state), 0);
        step(1000);
        chk("idle_state", int'(bus.state), 0);
        chk("idle_pulses", pulses - p0, 0);

        // Held next: one step at E0+10, no repeat.
        p0 = pulses;
        bus.btn_next = 1'b1;
        step(10);
        chk("held_before", int'(bus.state), 0);
        step(1);
        chk("held_state", int'(bus.state), 1);
        chk("held_chg", int'(bus.state_changed), 1);
        step(1);
        chk("held_chg_drop", int'(bus.state_changed), 0);
        step(8);
        chk("held_norepeat", int'(bus.state), 1);
        chk("held_pulses", pulses - p0, 1);
        bus.btn_next = 1'b0;
        step(15);

        // Bouncing next is rejected; clean presses wrap; prev from 0 wraps.
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 40; i++) begin
            bus.btn_next = ((i / 3) % 2 == 0);
            step(1);
        end
        bus.btn_next = 1'b0;
        step(15);
        chk("bounce_state", int'(bus.state), 0);
        chk("bounce_pulses", pulses - p0, 0);
        for (int k = 1; k <= 4; k++) begin
            press(0);
            chk("next_seq", int'(bus.state), k % NM);
        end
        press(1);
        chk("prev_wrap", int'(bus.state), 3);

        // Simultaneous next+prev cancels.
        p0 = pulses;
        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        step(20);
        chk("both_state", int'(bus.state), 3);
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        step(15);
        chk("both_pulses", pulses - p0, 0);

        // Auto-advance from state 2.
        do_reset();
        press(0);
        press(0);
        chk("auto_start", int'(bus.state), 2);
        bus.auto_en = 1'b1;
        wait_change(t1);
        chk("auto_tick1", int'(bus.state), 3);
        wait_change(t2);
        chk("auto_tick2", int'(bus.state), 0);
        chk("auto_period", t2 - t1, AC);
        // Press lands on the tick edge t2+32.
        step(21);
        bus.btn_next = 1'b1;
        wait_change(t3);
        chk("collide_time", t3 - t2, AC);
        chk("collide_state", int'(bus.state), 1);
        bus.btn_next = 1'b0;
        wait_change(t4);
        chk("collide_next", t4 - t3, AC);
        chk("collide_next_state", int'(bus.state), 2);
        // Press mid-period restarts the timer.
        step(5);
        bus.btn_next = 1'b1;
        wait_change(t5);
        chk("mid_press_time", t5 - t4, 16);
        chk("mid_press_state", int'(bus.state), 3);
        bus.btn_next = 1'b0;
        wait_change(t6);
        chk("restart_period", t6 - t5, AC);
        chk("restart_state", int'(bus.state), 0);
        bus.auto_en = 1'b0;
        step(5);

        // Reset mid-debounce with prev held.
        press(1);
        chk("pre_rst_state", int'(bus.state), 3);
        bus.btn_prev = 1'b1;
        step(5);
        sys_rst = 1'b1;
        step(1);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_chg", int'(bus.state_changed), 0);
        sys_rst = 1'b0;
        step(10);
        chk("rst_hold_before", int'(bus.state), 0);
        step(1);
        chk("rst_hold_state", int'(bus.state), 3);
        chk("rst_hold_chg", int'(bus.state_changed), 1);
        bus.btn_prev = 1'b0;
        step(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
